cpc_fifo_host_ctrl: RTL and testbench
=====================================

// Module: cpc_fifo_host_ctrl
// PURPOSE
//  CPLD-resident host-side controller between the CPC Z80 expansion bus and the two 40105 FIFO pairs.
//  Decodes CPC I/O cycles to a two-register port block. Drives the FIFO shift-in, shift-out,
//  output-enable and master-reset strobes, and returns a status byte to the CPC.
//  Sits directly upstream of the host->Pi FIFOs and downstream of the Pi->host FIFOs.
// PARAMETERS
//  BASE_ADDR    16'hFD80  I/O base; A[15:1]==BASE_ADDR[15:1] selects block, A[0] selects register
//  SI_CYCLES    1         host_fifo_si high-pulse width, CLK cycles (1..7)
//  SO_CYCLES    1         host_fifo_sob low-pulse width, CLK cycles (1..7)
//  RST_CYCLES   4         host_fifo_reset pulse width on software reset, CLK cycles (1..15)
// PORTS
//  CLK              in   1   CPC 4 MHz bus clock; single clock domain
//  RESET            in   1   synchronous, active-high reset
//  A                in   16  CPC address bus
//  D_IN             in   8   CPC data bus, input side of pad
//  D_OUT            out  8   data driven to CPC during status / empty-read cycles
//  D_OE             out  1   pad output enable for D_OUT
//  IOREQ_B          in   1   Z80 I/O request, active low
//  RD_B             in   1   Z80 read strobe, active low
//  WR_B             in   1   Z80 write strobe, active low
//  M1_B             in   1   Z80 M1, active low; M1_B=0 with IOREQ_B=0 is INT ack -> ignored
//  fifo_host_dir    in   1   host->Pi FIFO has space (DIR)
//  fifo_host_dor    in   1   Pi->host FIFO has data (DOR)
//  host_fifo_si     out  1   shift-in strobe, active high
//  host_fifo_sob    out  1   shift-out strobe, active low
//  host_fifo_oeb    out  1   Pi->host FIFO output enable, active low
//  host_fifo_reset  out  1   FIFO master reset, active high
// BEHAVIOUR
//  - Always decided: one clock CLK; RESET is synchronous and active-high.
//  - Reset: host_fifo_si=0, host_fifo_sob=1, host_fifo_oeb=1, D_OE=0, D_OUT=0, sticky flags=0,
//    state=IDLE. host_fifo_reset=1 throughout RESET and for the first cycle after RESET falls.
//  - All bus inputs are registered once; decode uses registered copies (1-cycle latency).
//  - sel = IOREQ_r==0 & M1_r==1 & A_r[15:1]==BASE_ADDR[15:1]. A cycle starts on the first cycle
//    where sel & (RD_r==0 | WR_r==0) holds and the previous cycle did not.
//  - Registers:
//    A0=0 write: DATA push. A0=0 read: DATA pop.
//    A0=1 read: STATUS = {4'b0, underflow, overflow, dir, dor}.
//    A0=1 write: D_IN[0]=1 triggers a software FIFO reset; other bits are ignored.
//  - FSM states: IDLE, PUSH, POP_OE, POP_SO, STAT, SRST, WAIT_END.
//    IDLE -> PUSH    on data write with dir=1. host_fifo_si=1 for SI_CYCLES, then -> WAIT_END.
//    IDLE -> WAIT_END on data write with dir=0 (full). No SI pulse; overflow sticky is set.
//    IDLE -> POP_OE  on data read with dor=1. oeb=0 from the next cycle until RD_r==1 is sampled.
//      Then -> POP_SO: sob=0 for SO_CYCLES, with oeb=1 throughout. Then -> WAIT_END.
//    Data read with dor=0 (empty): D_OUT=8'hFF and D_OE=1 while RD_r==0. Underflow sticky is set.
//      No oeb and no sob activity. -> WAIT_END.
//    IDLE -> STAT on status read. D_OUT=STATUS and D_OE=1 while RD_r==0, with dor/dir live.
//      At the end of the read, both sticky flags clear. -> WAIT_END.
//    IDLE -> SRST on control write with D_IN[0]=1. host_fifo_reset=1 for RST_CYCLES; sticky flags
//      clear. -> WAIT_END.
//    WAIT_END -> IDLE when IOREQ_r==1. No new cycle is accepted until then.
//  - Exactly one SI per write and exactly one SO per successful read, regardless of strobe length.
//  - D_OE never asserts on writes, and never while oeb=0 (no bus contention).
//  - If a set and a clear of the same sticky flag occur in one cycle, the set wins.
//  - RESET asserted mid-operation aborts any pulse on the next edge. No partial SI/SO pulse is
//    extended.
//  - Pulse counters are 3 bits (4 bits for RST). Parameter values outside their range are unsupported.
// TESTING
//  1. RESET 2 cycles -> reset=1 during RESET +1 cycle; si=0, sob=1, oeb=1, D_OE=0 afterwards.
//  2. OUT &FD80,&5A with dir=1 -> exactly one 1-cycle si pulse, starting 2 cycles after WR_B falls.
//  3. IN &FD80 with dor=1 -> oeb=0 while RD low. Then one 1-cycle sob pulse after RD_B rises, with oeb=1.
//  4. OUT &FD80 with dir=0, then IN &FD81 -> no si; status reads &06 (ovf=1, dir=1 restored).
//     A second IN &FD81 reads &02.
//  5. IN &FD80 with dor=0 -> D_OUT=&FF; no oeb/sob; the next status read has bit3=1.
//  6. OUT &FD81,&01 -> reset high 4 cycles. Also: RESET during a POP_SO -> sob=1 next edge, state IDLE.
//     Also: IOREQ with M1_B=0 at &FD80 -> no activity.

Source files
------------

// File: rtl/cpc_fifo_host_ctrl.sv
// rtl/cpc_fifo_host_ctrl.sv - CPC Z80 bus to 40105 FIFO pair host-side controller
//
// Decodes a two-register I/O block at BASE_ADDR (A0=0 data, A0=1 status/control) and
// turns CPC I/O cycles into FIFO shift-in / shift-out / output-enable / master-reset strobes.
//
// Ports:
//   CLK, RESET           single clock, synchronous active-high reset
//   A, D_IN              CPC address bus and data bus input side
//   D_OUT, D_OE          data returned to the CPC (status byte or 8'hFF on empty read)
//   IOREQ_B, RD_B, WR_B  Z80 bus strobes, active low
//   M1_B                 Z80 M1, active low (IOREQ with M1 low is an interrupt ack, ignored)
//   fifo_host_dir        host->Pi FIFO has space
//   fifo_host_dor        Pi->host FIFO has data
//   host_fifo_si         shift-in strobe, active high
//   host_fifo_sob        shift-out strobe, active low
//   host_fifo_oeb        Pi->host FIFO output enable, active low
//   host_fifo_reset      FIFO master reset, active high
module cpc_fifo_host_ctrl #(
  parameter logic [15:0] BASE_ADDR  = 16'hFD80,
  parameter int          SI_CYCLES  = 1,
  parameter int          SO_CYCLES  = 1,
  parameter int          RST_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] A,
  input  logic [7:0]  D_IN,
  output logic [7:0]  D_OUT,
  output logic        D_OE,
  input  logic        IOREQ_B,
  input  logic        RD_B,
  input  logic        WR_B,
  input  logic        M1_B,
  input  logic        fifo_host_dir,
  input  logic        fifo_host_dor,
  output logic        host_fifo_si,
  output logic        host_fifo_sob,
  output logic        host_fifo_oeb,
  output logic        host_fifo_reset
);

  localparam logic [3:0] SI_LAST  = 4'(SI_CYCLES - 1);
  localparam logic [3:0] SO_LAST  = 4'(SO_CYCLES - 1);
  localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, PUSH, POP_OE, POP_SO, STAT, SRST, WAIT_END
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] a_r;
  logic        d0_r;
  logic        ioreq_r, rd_r, wr_r, m1_r;
  logic        act_prev;
  logic [3:0]  cnt, cnt_nxt;
  logic        ovf, udf, ovf_nxt, udf_nxt;
  logic        ovf_set, udf_set, flag_clr;
  logic        empty_rd, empty_rd_nxt;
  logic        rst_d;
  logic        sel, act, start;
  logic        stat_drv, empty_drv;

  // Only D_IN[0] (software reset request) is ever looked at.
  assign sel   = !ioreq_r && m1_r && (a_r[15:1] == BASE_ADDR[15:1]);
  assign act   = sel && (!rd_r || !wr_r);
  assign start = act && !act_prev;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      a_r      <= 16'h0000;
      d0_r     <= 1'b0;
      ioreq_r  <= 1'b1;
      rd_r     <= 1'b1;
      wr_r     <= 1'b1;
      m1_r     <= 1'b1;
      act_prev <= 1'b0;
      cnt      <= 4'd0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
      empty_rd <= 1'b0;
      rst_d    <= 1'b1;
    end else begin
      state    <= state_nxt;
      a_r      <= A;
      d0_r     <= D_IN[0];
      ioreq_r  <= IOREQ_B;
      rd_r     <= RD_B;
      wr_r     <= WR_B;
      m1_r     <= M1_B;
      act_prev <= act;
      cnt      <= cnt_nxt;
      ovf      <= ovf_nxt;
      udf      <= udf_nxt;
      empty_rd <= empty_rd_nxt;
      rst_d    <= 1'b0;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    ovf_set      = 1'b0;
    udf_set      = 1'b0;
    flag_clr     = 1'b0;
    empty_rd_nxt = empty_rd;
    case (state)
      IDLE: begin
        empty_rd_nxt = 1'b0;
        if (start) begin
          if (!a_r[0]) begin
            if (!wr_r) begin
              if (fifo_host_dir) begin
                state_nxt = PUSH;
                cnt_nxt   = 4'd0;
              end else begin
                state_nxt = WAIT_END;
                ovf_set   = 1'b1;
              end
            end else if (fifo_host_dor) begin
              state_nxt = POP_OE;
            end else begin
              // Empty read: the 8'hFF is driven from WAIT_END while RD stays low.
              state_nxt    = WAIT_END;
              udf_set      = 1'b1;
              empty_rd_nxt = 1'b1;
            end
          end else if (!wr_r) begin
            if (d0_r) begin
              state_nxt = SRST;
              cnt_nxt   = 4'd0;
              flag_clr  = 1'b1;
            end else begin
              state_nxt = WAIT_END;
            end
          end else begin
            state_nxt = STAT;
          end
        end
      end
      PUSH: begin
        if (cnt == SI_LAST) state_nxt = WAIT_END;
        else                cnt_nxt   = cnt + 4'd1;
      end
      POP_OE: begin
        // Keep the FIFO output on the bus for the whole read strobe; shift out afterwards.
        if (rd_r) begin
          state_nxt = POP_SO;
          cnt_nxt   = 4'd0;
        end
      end
      POP_SO: begin
        if (cnt == SO_LAST) state_nxt = WAIT_END;
        else                cnt_nxt   = cnt + 4'd1;
      end
      STAT: begin
        if (rd_r) begin
          flag_clr  = 1'b1;
          state_nxt = WAIT_END;
        end
      end
      SRST: begin
        if (cnt == RST_LAST) state_nxt = WAIT_END;
        else                 cnt_nxt   = cnt + 4'd1;
      end
      WAIT_END: begin
        if (ioreq_r) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Set has priority over clear.
    ovf_nxt = ovf_set || (ovf && !flag_clr);
    udf_nxt = udf_set || (udf && !flag_clr);
  end

  assign stat_drv  = (state == STAT) && !rd_r;
  assign empty_drv = (state == WAIT_END) && empty_rd && !rd_r;

  assign host_fifo_si    = (state == PUSH);
  assign host_fifo_sob   = (state != POP_SO);
  assign host_fifo_oeb   = (state != POP_OE);
  assign host_fifo_reset = RESET || rst_d || (state == SRST);

  assign D_OE  = stat_drv || empty_drv;
  assign D_OUT = stat_drv  ? {4'b0000, udf, ovf, fifo_host_dir, fifo_host_dor} :
                 empty_drv ? 8'hFF : 8'h00;

endmodule

// File: tb/tb_cpc_fifo_host_ctrl.sv
// tb/tb_cpc_fifo_host_ctrl.sv - self-checking bench for cpc_fifo_host_ctrl
module tb_cpc_fifo_host_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] a = 16'h0000;
  logic [7:0]  d_in = 8'h00;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        ioreq_b = 1'b1, rd_b = 1'b1, wr_b = 1'b1, m1_b = 1'b1;
  logic        dir = 1'b1, dor = 1'b0;
  logic        si, sob, oeb, frst;

  always #5 clk = ~clk;

  cpc_fifo_host_ctrl dut (
    .CLK(clk), .RESET(reset), .A(a), .D_IN(d_in), .D_OUT(d_out), .D_OE(d_oe),
    .IOREQ_B(ioreq_b), .RD_B(rd_b), .WR_B(wr_b), .M1_B(m1_b),
    .fifo_host_dir(dir), .fifo_host_dor(dor),
    .host_fifo_si(si), .host_fifo_sob(sob), .host_fifo_oeb(oeb), .host_fifo_reset(frst)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: pulse statistics and the D_OUT scoreboard, sampled on the falling edge.
  logic [7:0] exp_q[$];
  int si_pulses = 0, si_hi = 0, sob_pulses = 0, sob_lo = 0, oeb_lo = 0;
  int rst_hi = 0, doe_hi = 0, bus_fight = 0;
  logic si_prev = 1'b0, sob_prev = 1'b1, doe_prev = 1'b0;

  always @(negedge clk) begin
    if (si === 1'b1 && !si_prev) si_pulses++;
    if (si === 1'b1) si_hi++;
    if (sob === 1'b0 && sob_prev) sob_pulses++;
    if (sob === 1'b0) sob_lo++;
    if (oeb === 1'b0) oeb_lo++;
    if (frst === 1'b1) rst_hi++;
    if (d_oe === 1'b1) doe_hi++;
    if (d_oe === 1'b1 && oeb === 1'b0) bus_fight++;
    if (d_oe === 1'b1 && !doe_prev) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_drive: got D_OUT=%02h expected no drive", d_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (d_out === e) n_pass++;
        else $display("FAIL sb_dout: got %02h expected %02h", d_out, e);
      end
    end
    si_prev  = (si === 1'b1);
    sob_prev = (sob !== 1'b0);
    doe_prev = (d_oe === 1'b1);
  end

  task automatic bus_cycle(input logic wr, input logic [15:0] addr,
                           input logic [7:0] data, input logic m1);
    @(posedge clk); #1;
    a = addr; d_in = data; m1_b = m1; ioreq_b = 1'b0;
    if (wr) wr_b = 1'b0; else rd_b = 1'b0;
    repeat (4) @(posedge clk); #1;
    ioreq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1; a = 16'h0000;
    repeat (8) @(posedge clk); #1;
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        dir;
    logic        dor;
    logic        m1;
    int          si;
    int          sob;
    int          oeb_lo;
    int          rst;
    logic        drv;
    logic [7:0]  dout;
  } vec_t;

  vec_t vt[16];

  initial begin
    //        wr    addr      data   dir   dor   m1    si sob oeb rst drv   dout
    vt[0]  = '{1'b1, 16'hFD80, 8'h5A, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0, 1'b0, 8'h00};
    vt[1]  = '{1'b0, 16'hFD80, 8'h00, 1'b1, 1'b1, 1'b1, 0, 1, 4, 0, 1'b0, 8'h00};
    vt[2]  = '{1'b1, 16'hFD80, 8'h33, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0, 8'h00};
    vt[3]  = '{1'b0, 16'hFD81, 8'h00, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 1'b1, 8'h06};
    vt[4]  = '{1'b0, 16'hFD81, 8'h00, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 1'b1, 8'h02};
    vt[5]  = '{1'b0, 16'hFD80, 8'h00, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 1'b1, 8'hFF};
    vt[6]  = '{1'b0, 16'hFD81, 8'h00, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 1'b1, 8'h0A};
    vt[7]  = '{1'b0, 16'hFD81, 8'h00, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 1'b1, 8'h01};
    vt[8]  = '{1'b1, 16'hFD81, 8'h01, 1'b1, 1'b0, 1'b1, 0, 0, 0, 4, 1'b0, 8'h00};
    vt[9]  = '{1'b1, 16'hFD80, 8'h11, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 8'h00};
    vt[10] = '{1'b0, 16'hFD80, 8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 8'h00};
    vt[11] = '{1'b1, 16'hFD82, 8'h22, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0, 8'h00};
    vt[12] = '{1'b1, 16'hFD81, 8'h02, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0, 8'h00};
    vt[13] = '{1'b1, 16'hFD80, 8'h44, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0, 8'h00};
    vt[14] = '{1'b1, 16'hFD81, 8'hFF, 1'b1, 1'b0, 1'b1, 0, 0, 0, 4, 1'b0, 8'h00};
    vt[15] = '{1'b0, 16'hFD81, 8'h00, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0, 1'b1, 8'h03};

    // Reset behaviour
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_during_reset", int'(frst), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_first_cycle_after", int'(frst), 1);
    check("reset_si", int'(si), 0);
    check("reset_sob", int'(sob), 1);
    check("reset_oeb", int'(oeb), 1);
    check("reset_doe", int'(d_oe), 0);
    @(negedge clk);
    check("rst_released", int'(frst), 0);

    // Shift-in latency: si high exactly on the second cycle after WR_B falls
    @(posedge clk); #1;
    dir = 1'b1; a = 16'hFD80; d_in = 8'h5A; ioreq_b = 1'b0; wr_b = 1'b0;
    @(posedge clk); @(negedge clk);
    check("si_lat_cycle1", int'(si), 0);
    @(posedge clk); @(negedge clk);
    check("si_lat_cycle2", int'(si), 1);
    @(posedge clk); @(negedge clk);
    check("si_lat_cycle3", int'(si), 0);
    @(posedge clk); #1;
    ioreq_b = 1'b1; wr_b = 1'b1; a = 16'h0000;
    repeat (8) @(posedge clk); #1;

    // Table-driven bus cycles
    for (int i = 0; i < 16; i++) begin
      int s_si, s_sih, s_sob, s_sobl, s_oeb, s_rst, s_doe;
      dir = vt[i].dir;
      dor = vt[i].dor;
      s_si = si_pulses; s_sih = si_hi; s_sob = sob_pulses; s_sobl = sob_lo;
      s_oeb = oeb_lo; s_rst = rst_hi; s_doe = doe_hi;
      if (vt[i].drv) exp_q.push_back(vt[i].dout);
      bus_cycle(vt[i].wr, vt[i].addr, vt[i].data, vt[i].m1);
      check($sformatf("v%0d_si_pulses", i), si_pulses - s_si, vt[i].si);
      check($sformatf("v%0d_si_cycles", i), si_hi - s_sih, vt[i].si);
      check($sformatf("v%0d_sob_pulses", i), sob_pulses - s_sob, vt[i].sob);
      check($sformatf("v%0d_sob_cycles", i), sob_lo - s_sobl, vt[i].sob);
      check($sformatf("v%0d_oeb_low_cycles", i), oeb_lo - s_oeb, vt[i].oeb_lo);
      check($sformatf("v%0d_rst_cycles", i), rst_hi - s_rst, vt[i].rst);
      check($sformatf("v%0d_doe_seen", i), int'((doe_hi - s_doe) > 0), int'(vt[i].drv));
      check($sformatf("v%0d_sb_drained", i), exp_q.size(), 0);
    end

    // RESET while shifting out aborts the sob pulse on the next edge
    begin
      bit seen;
      seen = 1'b0;
      dor = 1'b1;
      @(posedge clk); #1;
      a = 16'hFD80; ioreq_b = 1'b0; rd_b = 1'b0;
      repeat (2) @(posedge clk); #1;
      ioreq_b = 1'b1; rd_b = 1'b1; a = 16'h0000;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (sob === 1'b0) begin
          seen = 1'b1;
          break;
        end
      end
      check("abort_sob_reached", int'(seen), 1);
      reset = 1'b1;
      @(negedge clk);
      check("abort_sob_released", int'(sob), 1);
      check("abort_oeb_high", int'(oeb), 1);
      check("abort_fifo_reset", int'(frst), 1);
      @(posedge clk); #1;
      reset = 1'b0;
      dor = 1'b0;
      repeat (4) @(posedge clk); #1;
      exp_q.push_back(8'h02);
      bus_cycle(1'b0, 16'hFD81, 8'h00, 1'b1);
      check("post_abort_sb_drained", exp_q.size(), 0);
    end

    check("no_bus_contention", bus_fight, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
